wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, meaning: consecutive lost-arbitration cycles tolerated by a pending long-latency result before the pipeline is stalled; legal range 1..15.
REQ-002 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 wb_we_i  in  1  pipeline WB-stage register write enable.
REQ-005 wb_rd_i  in  5  pipeline WB-stage destination register.
REQ-006 wb_data_i  in  32  pipeline WB-stage data (output of the WB select mux).
REQ-007 llu_valid_i  in  1  long-latency unit result valid.
REQ-008 llu_ready_o  out  1  arbiter can accept the LLU result this cycle.
REQ-009 llu_rd_i  in  5  LLU destination register.
REQ-010 llu_data_i  in  32  LLU result data.
REQ-011 wb_stall_o  out  1  registered; pipeline holds its WB stage while high.
REQ-012 rf_we_o  out  1  register-file write enable.
REQ-013 rf_rd_o  out  5  register-file write address.
REQ-014 rf_wd_o  out  32  register-file write data.
REQ-015 pend_cnt_o  out  2  number of occupied buffer entries (0..2).

Function
REQ-016 The block SHALL share the single register-file write port between the pipeline WB stage and the LLU through a 2-entry in-order LLU buffer (FIFO).
REQ-017 llu_ready_o SHALL be 1 when pend_cnt_o < 2 and 0 otherwise (combinational from registered count).
REQ-018 An LLU transfer SHALL occur when llu_valid_i && llu_ready_o; if llu_rd_i == 0 the result is accepted and discarded (no push).
REQ-019 There SHALL be no bypass: an accepted LLU result reaches rf_we_o no earlier than the cycle after acceptance.
REQ-020 Grant per cycle: if wb_stall_o == 1 -> buffer head; else if wb_we_i && wb_rd_i != 0 -> pipeline; else if buffer non-empty -> buffer head; else no grant.
REQ-021 While wb_stall_o == 1, wb_we_i/wb_rd_i/wb_data_i SHALL be ignored (pipeline re-presents them after the stall).
REQ-022 rf_we_o/rf_rd_o/rf_wd_o SHALL be combinational from the grant; rf_we_o = 0 with no grant, on a killed head, or on rd == 0; rf_rd_o/rf_wd_o = 0 when rf_we_o == 0.
REQ-023 A buffer-head grant SHALL pop the head; push and pop in the same cycle leave the count unchanged.
REQ-024 Ordering: on a pipeline grant, every buffered entry with rd == wb_rd_i SHALL be marked killed (WAW squash); a killed entry still pops but produces rf_we_o = 0.
REQ-025 Starvation counter (4 bits): increments each cycle the buffer is non-empty and the pipeline is granted; clears on any pop or when the buffer is empty.
REQ-026 FSM NORM -> DRAIN when, in NORM, the counter equals STARVE_MAX-1 and the buffer loses arbitration again; wb_stall_o = 1 in every DRAIN cycle, 0 in NORM.
REQ-027 DRAIN -> NORM at the end of a cycle where the buffer becomes empty, or after 2 DRAIN cycles, whichever first; the starvation counter is 0 on exit.
REQ-028 An LLU push during DRAIN SHALL be accepted normally but SHALL NOT extend DRAIN beyond 2 cycles.
REQ-029 pend_cnt_o SHALL count killed entries until they pop.

Reset
REQ-030 While rst_i is high at a clock edge: buffer emptied (kill bits cleared), pend_cnt_o = 0, counter = 0, FSM = NORM, wb_stall_o = 0; llu_ready_o = 1 and rf_we_o = 0 from the following cycle.
REQ-031 Reset asserted mid-DRAIN or with pending entries SHALL discard those entries with no register-file write.

Verification
REQ-032 Idle pipeline, LLU writes x5 = 0xDEADBEEF at cycle 0 -> rf_we_o = 1, rf_rd_o = 5, rf_wd_o = 0xDEADBEEF at cycle 1, pend_cnt_o back to 0.
REQ-033 Pipeline writes every cycle (rd = 1..), LLU pushes x7 and x8 -> pend_cnt_o = 2, llu_ready_o = 0; with STARVE_MAX = 4, wb_stall_o rises after the 4th lost cycle, x7 then x8 written in the two DRAIN cycles, then NORM.
REQ-034 LLU pushes x3 = 0x11; next cycle pipeline writes x3 = 0x22 -> register file receives only 0x22; killed entry later pops with rf_we_o = 0.
REQ-035 Pipeline wb_rd_i = 0 with wb_we_i = 1 and a buffered entry -> buffered entry granted, no x0 write; LLU rd = 0 -> llu_ready_o honoured, pend_cnt_o unchanged.
REQ-036 rst_i pulsed for one cycle during DRAIN with 2 entries -> next cycle wb_stall_o = 0, pend_cnt_o = 0, rf_we_o = 0, llu_ready_o = 1.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the pipeline WB stage and a
// long-latency unit, buffering LLU results in a 2-entry in-order queue with WAW squash.
module wb_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    input  logic        llu_valid_i,
    output logic        llu_ready_o,
    input  logic [4:0]  llu_rd_i,
    input  logic [31:0] llu_data_i,
    output logic        wb_stall_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_wd_o,
    output logic [1:0]  pend_cnt_o
);

    localparam int unsigned RW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned CW = 2;

    typedef enum logic {NORM = 1'b0, DRAIN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic            drain_cyc_q;
    logic [SW-1:0]   starve_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            head_q;
    logic [RW-1:0]   slot_rd_q   [2];
    logic [DW-1:0]   slot_data_q [2];
    logic            slot_kill_q [2];

    logic buf_nempty, stall, pipe_gnt, pop, push, lost, tail;

    assign buf_nempty = (cnt_q != '0);
    assign stall      = (state_q == DRAIN);
    assign pipe_gnt   = !stall && wb_we_i && (wb_rd_i != '0);
    assign pop        = buf_nempty && (stall || !pipe_gnt);
    assign push       = llu_valid_i && llu_ready_o && (llu_rd_i != '0);
    assign lost       = pipe_gnt && buf_nempty;
    assign tail       = head_q ^ cnt_q[0];

    // Occupancy after this cycle's push/pop
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= NORM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter DRAIN on a starved loss, leave when empty or after two cycles
    always_comb begin
        state_d = state_q;
        case (state_q)
            NORM: begin
                if (lost && (starve_q == SW'(STARVE_MAX - 1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((cnt_d == '0) || drain_cyc_q) begin
                    state_d = NORM;
                end
            end
            default: state_d = NORM;
        endcase
    end

    // Outputs: grant mux onto the register-file port
    always_comb begin
        llu_ready_o = (cnt_q != CW'(2));
        wb_stall_o  = (state_q == DRAIN);
        pend_cnt_o  = cnt_q;
        rf_we_o     = 1'b0;
        rf_rd_o     = '0;
        rf_wd_o     = '0;
        if (!rst_i) begin
            if (pipe_gnt) begin
                rf_we_o = 1'b1;
                rf_rd_o = wb_rd_i;
                rf_wd_o = wb_data_i;
            end else if (pop && !slot_kill_q[head_q]) begin
                rf_we_o = 1'b1;
                rf_rd_o = slot_rd_q[head_q];
                rf_wd_o = slot_data_q[head_q];
            end
        end
    end

    // Buffer, starvation counter and DRAIN cycle tracking
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            head_q      <= 1'b0;
            starve_q    <= '0;
            drain_cyc_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                slot_rd_q[i]   <= '0;
                slot_data_q[i] <= '0;
                slot_kill_q[i] <= 1'b0;
            end
        end else begin
            cnt_q       <= cnt_d;
            drain_cyc_q <= (state_q == DRAIN);
            if (pop) begin
                head_q <= ~head_q;
            end
            if (pop || !buf_nempty) begin
                starve_q <= '0;
            end else if (lost) begin
                starve_q <= starve_q + SW'(1);
            end
            // Squash older buffered writes to the same register; a fresh push overrides
            if (pipe_gnt) begin
                for (int i = 0; i < 2; i++) begin
                    if (slot_rd_q[i] == wb_rd_i) begin
                        slot_kill_q[i] <= 1'b1;
                    end
                end
            end
            if (push) begin
                slot_rd_q[tail]   <= llu_rd_i;
                slot_data_q[tail] <= llu_data_i;
                slot_kill_q[tail] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wb_we_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        llu_valid_i;
    logic        llu_ready_o;
    logic [4:0]  llu_rd_i;
    logic [31:0] llu_data_i;
    logic        wb_stall_o;
    logic        rf_we_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_wd_o;
    logic [1:0]  pend_cnt_o;

    int checks = 0;
    int fails  = 0;

    wb_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .llu_valid_i(llu_valid_i), .llu_ready_o(llu_ready_o),
        .llu_rd_i(llu_rd_i), .llu_data_i(llu_data_i),
        .wb_stall_o(wb_stall_o), .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o),
        .rf_wd_o(rf_wd_o), .pend_cnt_o(pend_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Observed / expected tuple: ready, stall, pend, we, rd, wd
    wire  [41:0] obs = {llu_ready_o, wb_stall_o, pend_cnt_o, rf_we_o, rf_rd_o, rf_wd_o};
    logic [41:0] exp_v;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          kill;
    } ent_t;

    ent_t q[$];
    bit   m_drain;
    int   m_starve;
    int   m_dcyc;

    // Expected outputs from the model state and the current inputs
    task automatic model_eval;
        int n;
        bit pipe, bufg;
        logic e_we;
        logic [4:0] e_rd;
        logic [31:0] e_wd;
        n    = q.size();
        pipe = !m_drain && wb_we_i && (wb_rd_i != 0);
        bufg = (n > 0) && !pipe;
        e_we = 1'b0; e_rd = '0; e_wd = '0;
        if (!rst_i) begin
            if (pipe) begin
                e_we = 1'b1; e_rd = wb_rd_i; e_wd = wb_data_i;
            end else if (bufg && !q[0].kill) begin
                e_we = 1'b1; e_rd = q[0].rd; e_wd = q[0].data;
            end
        end
        exp_v = {(n < 2), m_drain, 2'(n), e_we, e_rd, e_wd};
    endtask

    // Advance the model across one rising edge
    task automatic model_update;
        int n, st_old;
        bit pipe, bufg, lost;
        if (rst_i) begin
            q.delete();
            m_drain = 0; m_starve = 0; m_dcyc = 0;
        end else begin
            n      = q.size();
            pipe   = !m_drain && wb_we_i && (wb_rd_i != 0);
            bufg   = (n > 0) && !pipe;
            lost   = pipe && (n > 0);
            st_old = m_starve;
            if (pipe) foreach (q[i]) if (q[i].rd == wb_rd_i) q[i].kill = 1;
            if (bufg) void'(q.pop_front());
            if (llu_valid_i && (n < 2) && (llu_rd_i != 0))
                q.push_back('{rd: llu_rd_i, data: llu_data_i, kill: 1'b0});
            if (bufg || n == 0) m_starve = 0;
            else if (lost) m_starve++;
            if (!m_drain) begin
                if (lost && st_old == STARVE_MAX - 1) begin
                    m_drain = 1; m_dcyc = 0;
                end
            end else begin
                m_dcyc++;
                if (q.size() == 0 || m_dcyc == 2) m_drain = 0;
            end
        end
    endtask

    task automatic set_in(input bit we, input logic [4:0] rd, input logic [31:0] d,
                          input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
        wb_we_i = we; wb_rd_i = rd; wb_data_i = d;
        llu_valid_i = lv; llu_rd_i = lrd; llu_data_i = ld;
        #1;
        model_eval();
    endtask

    task automatic next_cycle;
        model_update();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        next_cycle();
        rst_i = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== {1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'd0}) begin
            fails++;
            $display("FAIL reset_state: got %h expected %h", obs, {1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'd0});
        end
        next_cycle();
    endtask

    task automatic test_single_llu;
        for (int c = 0; c < 3; c++) begin
            set_in(0, 0, 0, c == 0, (c == 0) ? 5'd5 : 5'd0, (c == 0) ? 32'hDEADBEEF : 32'h0);
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL single_llu c=%0d: got %h expected %h", c, obs, exp_v);
            end
            if (c == 0) begin
                checks++;
                if (rf_we_o !== 1'b0) begin
                    fails++;
                    $display("FAIL no_bypass: rf_we got %b expected 0", rf_we_o);
                end
            end
            if (c == 1) begin
                checks++;
                if ({rf_we_o, rf_rd_o, rf_wd_o} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
                    fails++;
                    $display("FAIL llu_write: got we=%b rd=%0d wd=%h expected 1/5/deadbeef",
                             rf_we_o, rf_rd_o, rf_wd_o);
                end
            end
            if (c == 2) begin
                checks++;
                if (pend_cnt_o !== 2'd0) begin
                    fails++;
                    $display("FAIL llu_drained: pend got %0d expected 0", pend_cnt_o);
                end
            end
            next_cycle();
        end
    endtask

    // Pipeline writes every cycle; LLU pushes x7, x8; stops after cycle `upto`
    task automatic starve_seq(input int upto, input bit rst_at_end);
        for (int c = 0; c <= upto; c++) begin
            rst_i = rst_at_end && (c == upto);
            set_in(1, 5'(c + 1), 32'h100 + 32'(c), c < 2, 5'(7 + c), 32'h70 + 32'(c));
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL starve c=%0d: got %h expected %h", c, obs, exp_v);
            end
            if (c == 2 || c == 4) begin
                checks++;
                if ({pend_cnt_o, llu_ready_o, wb_stall_o} !== {2'd2, 1'b0, 1'b0}) begin
                    fails++;
                    $display("FAIL starve_full c=%0d: pend=%0d ready=%b stall=%b expected 2/0/0",
                             c, pend_cnt_o, llu_ready_o, wb_stall_o);
                end
            end
            if ((c == 5 || c == 6) && !rst_at_end) begin
                checks++;
                if ({wb_stall_o, rf_we_o, rf_rd_o} !== {1'b1, 1'b1, 5'(c + 2)}) begin
                    fails++;
                    $display("FAIL drain c=%0d: stall=%b we=%b rd=%0d expected 1/1/%0d",
                             c, wb_stall_o, rf_we_o, rf_rd_o, c + 2);
                end
            end
            if (c == 7) begin
                checks++;
                if ({wb_stall_o, rf_rd_o} !== {1'b0, 5'd8}) begin
                    fails++;
                    $display("FAIL drain_exit: stall=%b rd=%0d expected 0/8", wb_stall_o, rf_rd_o);
                end
            end
            next_cycle();
        end
        rst_i = 1'b0;
    endtask

    task automatic test_starve_drain;
        starve_seq(8, 1'b0);
    endtask

    task automatic test_waw_squash;
        for (int c = 0; c < 4; c++) begin
            set_in(c == 1, (c == 1) ? 5'd3 : 5'd0, 32'h22, c == 0, 5'd3, 32'h11);
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL waw c=%0d: got %h expected %h", c, obs, exp_v);
            end
            if (c == 2) begin
                checks++;
                if ({rf_we_o, pend_cnt_o} !== {1'b0, 2'd1}) begin
                    fails++;
                    $display("FAIL waw_killed_pop: we=%b pend=%0d expected 0/1", rf_we_o, pend_cnt_o);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_rd_zero;
        for (int c = 0; c < 3; c++) begin
            set_in(c == 1, 5'd0, 32'h55, c < 2, (c == 0) ? 5'd9 : 5'd0, 32'h99);
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL rd_zero c=%0d: got %h expected %h", c, obs, exp_v);
            end
            if (c == 1) begin
                checks++;
                if ({rf_we_o, rf_rd_o, rf_wd_o, llu_ready_o} !== {1'b1, 5'd9, 32'h99, 1'b1}) begin
                    fails++;
                    $display("FAIL rd_zero_grant: we=%b rd=%0d wd=%h ready=%b expected 1/9/99/1",
                             rf_we_o, rf_rd_o, rf_wd_o, llu_ready_o);
                end
            end
            if (c == 2) begin
                checks++;
                if (pend_cnt_o !== 2'd0) begin
                    fails++;
                    $display("FAIL rd_zero_discard: pend got %0d expected 0", pend_cnt_o);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_in_drain;
        starve_seq(5, 1'b1);
        set_in(0, 0, 0, 0, 0, 0);
        checks++;
        if ({wb_stall_o, pend_cnt_o, rf_we_o, llu_ready_o} !== {1'b0, 2'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_in_drain: stall=%b pend=%0d we=%b ready=%b expected 0/0/0/1",
                     wb_stall_o, pend_cnt_o, rf_we_o, llu_ready_o);
        end
        next_cycle();
    endtask

    task automatic test_random;
        for (int c = 0; c < 600; c++) begin
            rst_i = ($urandom_range(0, 99) == 0);
            set_in($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom(),
                   $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom());
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL random c=%0d: got %h expected %h", c, obs, exp_v);
            end
            next_cycle();
        end
        rst_i = 1'b0;
    endtask

    initial begin
        q.delete();
        m_drain = 0; m_starve = 0; m_dcyc = 0;
        rst_i = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        @(posedge clk_i);
        #1;
        test_reset();
        test_single_llu();
        test_starve_drain();
        test_waw_squash();
        test_rd_zero();
        test_reset_in_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
